// File: rtl/mac_pe_pipe_if.sv
// mac_pe_pipe_if: operand/accumulator bundle for one systolic MAC processing element.
//   master : array controller / neighbour side (drives en, WrEn, clr, valid_in, Ain, Bin, Cin)
//   slave  : the PE itself (drives Aout, Bout, valid_out, Cout, ovf, pipe_busy)
//   en        advance enable (0 = stall)
//   WrEn      preload accumulator from Cin
//   clr       clear accumulator and overflow flag
//   valid_in  Ain/Bin pair is a real operand
//   Ain, Bin  signed operands; Cin signed preload value
//   Aout/Bout registered operands to east/south neighbours, valid_out travels with them
//   Cout      accumulator; ovf sticky overflow; pipe_busy valid product still in flight
interface mac_pe_pipe_if #(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16
);
  logic                      en;
  logic                      WrEn;
  logic                      clr;
  logic                      valid_in;
  logic signed [BITS_AB-1:0] Ain;
  logic signed [BITS_AB-1:0] Bin;
  logic signed [BITS_C-1:0]  Cin;
  logic signed [BITS_AB-1:0] Aout;
  logic signed [BITS_AB-1:0] Bout;
  logic                      valid_out;
  logic signed [BITS_C-1:0]  Cout;
  logic                      ovf;
  logic                      pipe_busy;

  modport master (
    output en, WrEn, clr, valid_in, Ain, Bin, Cin,
    input  Aout, Bout, valid_out, Cout, ovf, pipe_busy
  );

  modport slave (
    input  en, WrEn, clr, valid_in, Ain, Bin, Cin,
    output Aout, Bout, valid_out, Cout, ovf, pipe_busy
  );
endinterface

// File: rtl/mac_pe_pipe.sv
// mac_pe_pipe: systolic MAC processing element with a configurable multiplier pipeline.
// Forwards Ain/Bin/valid_in one en-cycle later, multiplies Ain*Bin (signed), carries the
// product through MUL_STAGES registers tagged with valid_in, and adds tagged products into
// a BITS_C accumulator with wrap (SATURATE=0) or clamp (SATURATE=1) arithmetic.
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset, overrides everything
//   io     mac_pe_pipe_if.slave (see interface file for signal list)
// Per-edge priority: rst_n > WrEn > clr > en. WrEn/clr flush the pipe and hold Aout/Bout.
module mac_pe_pipe #(
  parameter int BITS_AB    = 8,
  parameter int BITS_C     = 16,
  parameter int MUL_STAGES = 1,
  parameter int SATURATE   = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  mac_pe_pipe_if.slave  io
);
  localparam int BITS_P = 2 * BITS_AB;
  // Pipe arrays need at least one entry even when MUL_STAGES=0 leaves them unused.
  localparam int PS     = (MUL_STAGES > 0) ? MUL_STAGES : 1;

  localparam logic signed [BITS_C-1:0] C_MAX = {1'b0, {(BITS_C-1){1'b1}}};
  localparam logic signed [BITS_C-1:0] C_MIN = {1'b1, {(BITS_C-1){1'b0}}};

  generate
    if (MUL_STAGES < 0 || MUL_STAGES > 3) begin : g_bad_stages
      $error("mac_pe_pipe: MUL_STAGES must be in 0..3");
    end
    if (BITS_C < 2 * BITS_AB) begin : g_bad_width
      $error("mac_pe_pipe: BITS_C must be >= 2*BITS_AB");
    end
  endgenerate

  logic signed [BITS_AB-1:0] aout_q, bout_q;
  logic                      vout_q;
  logic signed [BITS_C-1:0]  cout_q, cout_d;
  logic                      ovf_q, ovf_d;

  logic signed [BITS_P-1:0]  p_now;   // product of the operands being sampled now
  logic signed [BITS_P-1:0]  acc_p;   // product presented to the accumulator this edge
  logic                      acc_v;
  logic                      busy;
  logic signed [BITS_C:0]    sum;
  logic                      sum_ovf;

  assign p_now = io.Ain * io.Bin;

  generate
    if (MUL_STAGES == 0) begin : g_comb
      assign acc_p = p_now;
      assign acc_v = io.valid_in;
      assign busy  = 1'b0;
    end else begin : g_pipe
      logic signed [BITS_P-1:0] prod_q [PS];
      logic        [PS-1:0]     tag_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          // NOTE: the product registers are reset along with their tags so that
          // no pre-reset value can ever reach the accumulator after release.
          for (int i = 0; i < PS; i++) prod_q[i] <= '0;
          tag_q <= '0;
        end else if (io.WrEn || io.clr) begin
          // Flushing only the tags is enough to discard in-flight products.
          tag_q <= '0;
        end else if (io.en) begin
          prod_q[0] <= p_now;
          tag_q[0]  <= io.valid_in;
          for (int i = 1; i < PS; i++) begin
            prod_q[i] <= prod_q[i-1];
            tag_q[i]  <= tag_q[i-1];
          end
        end
      end

      assign acc_p = prod_q[PS-1];
      assign acc_v = tag_q[PS-1];
      assign busy  = |tag_q;
    end
  endgenerate

  // Add in BITS_C+1 bits; overflow shows as disagreement of the top two bits.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    sum     = $signed({cout_q[BITS_C-1], cout_q})
            + $signed({{(BITS_C + 1 - BITS_P){acc_p[BITS_P-1]}}, acc_p});
    sum_ovf = sum[BITS_C] ^ sum[BITS_C-1];
    if (acc_v) begin
      if (sum_ovf) begin
        ovf_d  = 1'b1;
        cout_d = (SATURATE != 0) ? (sum[BITS_C] ? C_MIN : C_MAX) : sum[BITS_C-1:0];
      end else begin
        cout_d = sum[BITS_C-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      aout_q <= '0;
      bout_q <= '0;
      vout_q <= 1'b0;
      cout_q <= '0;
      ovf_q  <= 1'b0;
    end else if (io.WrEn) begin
      cout_q <= io.Cin;
      ovf_q  <= 1'b0;
    end else if (io.clr) begin
      cout_q <= '0;
      ovf_q  <= 1'b0;
    end else if (io.en) begin
      aout_q <= io.Ain;
      bout_q <= io.Bin;
      vout_q <= io.valid_in;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign io.Aout      = aout_q;
  assign io.Bout      = bout_q;
  assign io.valid_out = vout_q;
  assign io.Cout      = cout_q;
  assign io.ovf       = ovf_q;
  assign io.pipe_busy = busy;
endmodule

// File: tb/tb_mac_pe_pipe.sv
// tb_mac_pe_pipe: directed bench for mac_pe_pipe. Three PEs share one stimulus:
//   u_w0 : MUL_STAGES=0, wrap      u_s0 : MUL_STAGES=0, saturate
//   u_w2 : MUL_STAGES=2, wrap
// A vector table covers the single-cycle PEs; hand sequences cover pipe latency,
// stall, flush and reset of the two-stage PE.
module tb_mac_pe_pipe;
  logic              clk = 1'b0;
  logic              rst_n;
  logic              en, wren, clr, vin;
  logic signed [7:0] ain, bin;
  logic signed [15:0] cin;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mac_pe_pipe_if #(.BITS_AB(8), .BITS_C(16)) if_w0 ();
  mac_pe_pipe_if #(.BITS_AB(8), .BITS_C(16)) if_s0 ();
  mac_pe_pipe_if #(.BITS_AB(8), .BITS_C(16)) if_w2 ();

  assign if_w0.en = en;  assign if_w0.WrEn = wren; assign if_w0.clr = clr;
  assign if_w0.valid_in = vin; assign if_w0.Ain = ain; assign if_w0.Bin = bin;
  assign if_w0.Cin = cin;
  assign if_s0.en = en;  assign if_s0.WrEn = wren; assign if_s0.clr = clr;
  assign if_s0.valid_in = vin; assign if_s0.Ain = ain; assign if_s0.Bin = bin;
  assign if_s0.Cin = cin;
  assign if_w2.en = en;  assign if_w2.WrEn = wren; assign if_w2.clr = clr;
  assign if_w2.valid_in = vin; assign if_w2.Ain = ain; assign if_w2.Bin = bin;
  assign if_w2.Cin = cin;

  mac_pe_pipe #(.BITS_AB(8), .BITS_C(16), .MUL_STAGES(0), .SATURATE(0))
    u_w0 (.clk(clk), .rst_n(rst_n), .io(if_w0));
  mac_pe_pipe #(.BITS_AB(8), .BITS_C(16), .MUL_STAGES(0), .SATURATE(1))
    u_s0 (.clk(clk), .rst_n(rst_n), .io(if_s0));
  mac_pe_pipe #(.BITS_AB(8), .BITS_C(16), .MUL_STAGES(2), .SATURATE(0))
    u_w2 (.clk(clk), .rst_n(rst_n), .io(if_w2));

  typedef struct {
    logic        wren, clr, en, v;
    int          a, b, c;
    int          aout, bout, vout;
    int          cw, ow;   // wrap PE: Cout, ovf
    int          cs, os;   // saturating PE: Cout, ovf
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply the current inputs across one rising edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic c, input logic e, input logic v,
                       input int a, input int b, input int ci);
    wren = w; clr = c; en = e; vin = v;
    ain = 8'(a); bin = 8'(b); cin = 16'(ci);
  endtask

  vec_t vecs[14];

  initial begin
    //          wren clr en v  a     b     cin     aout  bout vout cw      ow cs      os
    vecs[0]  = '{1, 0, 1, 1,  9,    9,    5,      0,    0,   0,   5,      0, 5,      0};
    vecs[1]  = '{0, 0, 1, 1,  3,    4,    0,      3,    4,   1,   17,     0, 17,     0};
    vecs[2]  = '{0, 0, 1, 0,  7,    7,    0,      7,    7,   0,   17,     0, 17,     0};
    vecs[3]  = '{0, 0, 0, 1,  5,    5,    0,      7,    7,   0,   17,     0, 17,     0};
    vecs[4]  = '{0, 0, 1, 1,  -2,   5,    0,      -2,   5,   1,   7,      0, 7,      0};
    vecs[5]  = '{1, 0, 1, 1,  1,    1,    32760,  -2,   5,   1,   32760,  0, 32760,  0};
    vecs[6]  = '{0, 0, 1, 1,  3,    4,    0,      3,    4,   1,   -32764, 1, 32767,  1};
    vecs[7]  = '{0, 0, 1, 1,  0,    0,    0,      0,    0,   1,   -32764, 1, 32767,  1};
    vecs[8]  = '{1, 0, 1, 1,  1,    1,    -32763, 0,    0,   1,   -32763, 0, -32763, 0};
    vecs[9]  = '{0, 0, 1, 1,  -3,   4,    0,      -3,   4,   1,   32761,  1, -32768, 1};
    vecs[10] = '{0, 1, 1, 1,  1,    1,    0,      -3,   4,   1,   0,      0, 0,      0};
    vecs[11] = '{0, 0, 1, 1,  -128, -128, 0,      -128, -128,1,   16384,  0, 16384,  0};
    vecs[12] = '{0, 0, 1, 1,  -128, -128, 0,      -128, -128,1,   -32768, 1, 32767,  1};
    vecs[13] = '{1, 1, 1, 1,  1,    1,    50,     -128, -128,1,   50,     0, 50,     0};

    // Reset with busy-looking inputs: reset must win.
    rst_n = 1'b0;
    drive(1, 1, 1, 1, 3, 4, 99);
    tick();
    check("rst_aout",  if_w0.Aout, 0);
    check("rst_vout",  if_w0.valid_out, 0);
    check("rst_cout",  if_w0.Cout, 0);
    check("rst_ovf",   if_s0.ovf, 0);
    check("rst_busy2", if_w2.pipe_busy, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].wren, vecs[i].clr, vecs[i].en, vecs[i].v, vecs[i].a, vecs[i].b, vecs[i].c);
      tick();
      check($sformatf("v%0d_aout", i), if_w0.Aout, vecs[i].aout);
      check($sformatf("v%0d_bout", i), if_w0.Bout, vecs[i].bout);
      check($sformatf("v%0d_vout", i), if_w0.valid_out, vecs[i].vout);
      check($sformatf("v%0d_cw", i), if_w0.Cout, vecs[i].cw);
      check($sformatf("v%0d_ow", i), if_w0.ovf, vecs[i].ow);
      check($sformatf("v%0d_cs", i), if_s0.Cout, vecs[i].cs);
      check($sformatf("v%0d_os", i), if_s0.ovf, vecs[i].os);
      check($sformatf("v%0d_busy0", i), if_w0.pipe_busy, 0);
    end

    // Two-stage latency: sample at t, add at t+2.
    drive(1, 0, 1, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 1, 2, 3, 0); tick();
    check("lat_t_cout", if_w2.Cout, 0);
    check("lat_t_busy", if_w2.pipe_busy, 1);
    drive(0, 0, 1, 0, 0, 0, 0); tick();
    check("lat_t1_cout", if_w2.Cout, 0);
    check("lat_t1_busy", if_w2.pipe_busy, 1);
    tick();
    check("lat_t2_cout", if_w2.Cout, 6);
    check("lat_t2_busy", if_w2.pipe_busy, 0);

    // Same with a stall at t+1: the update moves to t+3.
    drive(1, 0, 1, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 1, 2, 3, 0); tick();
    drive(0, 0, 0, 1, 9, 9, 0); tick();
    check("stall_t1_cout", if_w2.Cout, 0);
    check("stall_t1_busy", if_w2.pipe_busy, 1);
    check("stall_t1_aout", if_w2.Aout, 2);
    drive(0, 0, 1, 0, 0, 0, 0); tick();
    check("stall_t2_cout", if_w2.Cout, 0);
    tick();
    check("stall_t3_cout", if_w2.Cout, 6);
    check("stall_t3_busy", if_w2.pipe_busy, 0);

    // Preload flushes in-flight products.
    drive(1, 0, 1, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 1, 2, 3, 0); tick();
    drive(0, 0, 1, 1, 4, 5, 0); tick();
    check("flush_busy_pre", if_w2.pipe_busy, 1);
    drive(1, 0, 1, 0, 0, 0, 100); tick();
    check("flush_cout", if_w2.Cout, 100);
    check("flush_busy", if_w2.pipe_busy, 0);
    check("flush_aout_hold", if_w2.Aout, 4);
    drive(0, 0, 1, 0, 7, 7, 0); tick();
    drive(0, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("flush_hold%0d", k), if_w2.Cout, 100);
    end
    check("flush_busy_end", if_w2.pipe_busy, 0);

    // Reset with a full pipe and a non-zero accumulator.
    drive(1, 0, 1, 0, 0, 0, 1234); tick();
    drive(0, 0, 1, 1, 2, 3, 0); tick();
    drive(0, 0, 1, 1, 4, 5, 0); tick();
    check("prerst_cout", if_w2.Cout, 1234);
    rst_n = 1'b0; tick();
    check("rst2_cout", if_w2.Cout, 0);
    check("rst2_aout", if_w2.Aout, 0);
    check("rst2_bout", if_w2.Bout, 0);
    check("rst2_vout", if_w2.valid_out, 0);
    check("rst2_ovf",  if_w2.ovf, 0);
    check("rst2_busy", if_w2.pipe_busy, 0);
    rst_n = 1'b1;
    drive(0, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("postrst_cout%0d", k), if_w2.Cout, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
